// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, rx alignment state and
// the bit-offset helpers used by the word aligner.
package tmds_pkg;

  localparam int OFFSET_W = 4;
  localparam logic [OFFSET_W-1:0] OFFSET_MAX = 4'd9;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } rx_state_t;

  function automatic logic is_token(input logic [9:0] w);
    return (w == TOKEN_C00) || (w == TOKEN_C01) ||
           (w == TOKEN_C10) || (w == TOKEN_C11);
  endfunction

  function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
    return (off == OFFSET_MAX) ? '0 : off + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: 10-bit aligned word to {de, ctrl, data}.
// Control tokens yield de=0; every other word is decoded as video data.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_word,
  output logic       o_de,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_data
);

  logic [7:0] w_d;
  logic [7:0] w_q;

  // Bit 9 marks an inverted payload; bit 8 selects XOR vs XNOR chaining.
  assign w_d = i_word[9] ? ~i_word[7:0] : i_word[7:0];

  always_comb begin
    w_q    = '0;
    w_q[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_q[i] = i_word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  always_comb begin
    o_de   = 1'b1;
    o_ctrl = 2'b00;
    o_data = w_q;
    case (i_word)
      TOKEN_C00: begin o_de = 1'b0; o_ctrl = 2'b00; o_data = '0; end
      TOKEN_C01: begin o_de = 1'b0; o_ctrl = 2'b01; o_data = '0; end
      TOKEN_C10: begin o_de = 1'b0; o_ctrl = 2'b10; o_data = '0; end
      TOKEN_C11: begin o_de = 1'b0; o_ctrl = 2'b11; o_data = '0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS receive channel: bit-offset word aligner locked on control tokens,
// followed by a two-stage decode pipeline. TMDS_RX_DEBUG_EN adds o_offset/o_relock_cnt.
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_WINDOW = 1024,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic       clk_pixel,
  input  logic       rst,
  input  logic [9:0] i_raw,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_locked
`ifdef TMDS_RX_DEBUG_EN
  ,
  output logic [3:0] o_offset,
  output logic [7:0] o_relock_cnt
`endif
);

  localparam int RUN_W  = (TOKEN_RUN     > 1) ? $clog2(TOKEN_RUN)     : 1;
  localparam int WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int IDLE_W = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

  rx_state_t           r_state;
  logic                r_locked;
  logic [OFFSET_W-1:0] r_offset;
  logic [RUN_W-1:0]    r_run_cnt;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;
`ifdef TMDS_RX_DEBUG_EN
  logic [7:0]          r_relock_cnt;
`endif

  logic [9:0]  r_prev;
  logic [9:0]  r_cand;
  logic [7:0]  r_data;
  logic [1:0]  r_ctrl;
  logic        r_de;

  logic [19:0] w_window;
  logic [19:0] w_shifted;
  logic [9:0]  w_cand;
  logic        w_tok;
  logic        w_go_lock;
  logic        w_win_end;
  logic        w_drop;
  logic        w_lock_next;
  logic        w_dec_de;
  logic [1:0]  w_dec_ctrl;
  logic [7:0]  w_dec_data;

  // Offset k means k junk bits precede the true word inside {current, previous}.
  assign w_window  = {i_raw, r_prev};
  assign w_shifted = w_window >> r_offset;
  assign w_cand    = w_shifted[9:0];
  assign w_tok     = is_token(w_cand);

  assign w_go_lock   = (r_state == SEARCH) && w_tok && (r_run_cnt == RUN_LAST);
  assign w_win_end   = (r_state == SEARCH) && (r_win_cnt == WIN_LAST);
  assign w_drop      = (r_state == LOCKED) && !w_tok && (r_idle_cnt == IDLE_LAST);
  assign w_lock_next = w_go_lock || ((r_state == LOCKED) && !w_drop);

  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) begin
      r_state    <= SEARCH;
      r_locked   <= 1'b0;
      r_offset   <= '0;
      r_run_cnt  <= '0;
      r_win_cnt  <= '0;
      r_idle_cnt <= '0;
`ifdef TMDS_RX_DEBUG_EN
      r_relock_cnt <= '0;
`endif
    end else begin
      case (r_state)
        SEARCH: begin
          // Lock takes priority over window expiry; the offset stays put.
          if (w_go_lock) begin
            r_state    <= LOCKED;
            r_locked   <= 1'b1;
            r_run_cnt  <= '0;
            r_win_cnt  <= '0;
            r_idle_cnt <= '0;
          end else if (w_win_end) begin
            r_offset  <= next_offset(r_offset);
            r_run_cnt <= '0;
            r_win_cnt <= '0;
          end else begin
            r_run_cnt <= w_tok ? r_run_cnt + 1'b1 : '0;
            r_win_cnt <= r_win_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (w_drop) begin
            r_state    <= SEARCH;
            r_locked   <= 1'b0;
            r_offset   <= next_offset(r_offset);
            r_run_cnt  <= '0;
            r_win_cnt  <= '0;
            r_idle_cnt <= '0;
`ifdef TMDS_RX_DEBUG_EN
            if (r_relock_cnt != 8'hFF) r_relock_cnt <= r_relock_cnt + 1'b1;
`endif
          end else begin
            r_idle_cnt <= w_tok ? '0 : r_idle_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  tmds_symbol_decode u_decode (
    .i_word (r_cand),
    .o_de   (w_dec_de),
    .o_ctrl (w_dec_ctrl),
    .o_data (w_dec_data)
  );

  // Gate with the next lock value so outputs are zero exactly when o_locked is 0.
  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) begin
      r_prev <= '0;
      r_cand <= '0;
      r_data <= '0;
      r_ctrl <= '0;
      r_de   <= 1'b0;
    end else begin
      r_prev <= i_raw;
      r_cand <= w_cand;
      if (w_lock_next) begin
        r_data <= w_dec_data;
        r_ctrl <= w_dec_ctrl;
        r_de   <= w_dec_de;
      end else begin
        r_data <= '0;
        r_ctrl <= '0;
        r_de   <= 1'b0;
      end
    end
  end

  assign o_data   = r_data;
  assign o_ctrl   = r_ctrl;
  assign o_de     = r_de;
  assign o_locked = r_locked;
`ifdef TMDS_RX_DEBUG_EN
  assign o_offset     = r_offset;
  assign o_relock_cnt = r_relock_cnt;
`endif

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed bench for tmds_channel_rx with a 64-word search window and lock timeout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tmds_channel_rx;

  localparam int TOKEN_RUN = 8;
  localparam int SWIN      = 64;
  localparam int LTO       = 64;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] DATA_ZERO = 10'b0100000000;

  logic       clk_pixel;
  logic       rst;
  logic [9:0] i_raw;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
`ifdef TMDS_RX_DEBUG_EN
  logic [3:0] o_offset;
  logic [7:0] o_relock_cnt;
`endif

  int n_checks;
  int n_fail;

  tmds_channel_rx #(
    .TOKEN_RUN     (TOKEN_RUN),
    .SEARCH_WINDOW (SWIN),
    .LOCK_TIMEOUT  (LTO)
  ) dut (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .i_raw     (i_raw),
    .o_data    (o_data),
    .o_ctrl    (o_ctrl),
    .o_de      (o_de),
    .o_locked  (o_locked)
`ifdef TMDS_RX_DEBUG_EN
    ,
    .o_offset     (o_offset),
    .o_relock_cnt (o_relock_cnt)
`endif
  );

  // clock / reset
  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  // Present one word for one full clock; returns on the next falling edge.
  task automatic drive(input logic [9:0] w);
    i_raw = w;
    @(negedge clk_pixel);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      drive(10'($urandom_range(0, 1023)));
      n_checks++;
      if ({o_locked, o_de, o_ctrl, o_data} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got locked=%b de=%b ctrl=%b data=%h want all 0",
                 i, o_locked, o_de, o_ctrl, o_data);
      end
    end
  endtask

  // Three junk bits precede a continuous C=00 stream, so words arrive rotated.
  task automatic test_misaligned_lock;
    logic [9:0] rot;
    int lock_at;
    rot = {T00[6:0], T00[9:7]};
    lock_at = -1;
    rst = 1'b1;
    drive({T00[6:0], 3'b101});
    for (int n = 2; n <= 3*SWIN + TOKEN_RUN + 4; n++) begin
      drive(rot);
      if (o_locked === 1'b1 && lock_at < 0) lock_at = n;
    end
    n_checks++;
    if (lock_at < 0) begin
      n_fail++;
      $display("FAIL misaligned_lock_timeout got no lock want lock within %0d cycles",
               3*SWIN + TOKEN_RUN + 4);
    end
    n_checks++;
    if (lock_at >= 0 && lock_at < 3*SWIN) begin
      n_fail++;
      $display("FAIL misaligned_lock_early got lock at cycle %0d want >= %0d", lock_at, 3*SWIN);
    end
    drive(rot);
    n_checks++;
    if (o_de !== 1'b0 || o_ctrl !== 2'b00) begin
      n_fail++;
      $display("FAIL misaligned_decode got de=%b ctrl=%b want de=0 ctrl=00", o_de, o_ctrl);
    end
`ifdef TMDS_RX_DEBUG_EN
    n_checks++;
    if (o_offset !== 4'd3) begin
      n_fail++;
      $display("FAIL misaligned_offset got %0d want 3", o_offset);
    end
`endif
  endtask

  task automatic test_reset_while_locked;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({o_locked, o_de, o_ctrl, o_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid got locked=%b de=%b ctrl=%b data=%h want all 0",
               o_locked, o_de, o_ctrl, o_data);
    end
`ifdef TMDS_RX_DEBUG_EN
    n_checks++;
    if (o_offset !== 4'd0 || o_relock_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dbg got offset=%0d relock=%0d want 0 0", o_offset, o_relock_cnt);
    end
`endif
    @(negedge clk_pixel);
  endtask

  // Aligned stream from offset 0: lock appears after TOKEN_RUN+1 clocks.
  task automatic test_aligned_lock;
    rst = 1'b1;
    for (int i = 0; i < TOKEN_RUN; i++) drive(T00);
    n_checks++;
    if (o_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_lock_early got locked=%b want 0 after %0d cycles", o_locked, TOKEN_RUN);
    end
    drive(T00);
    n_checks++;
    if (o_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL aligned_lock got locked=%b want 1 after %0d cycles", o_locked, TOKEN_RUN + 1);
    end
    drive(T00);
    drive(T00);
    n_checks++;
    if (o_de !== 1'b0 || o_ctrl !== 2'b00 || o_data !== 8'h00) begin
      n_fail++;
      $display("FAIL aligned_ctrl got de=%b ctrl=%b data=%h want de=0 ctrl=00 data=00",
               o_de, o_ctrl, o_data);
    end
  endtask

  task automatic test_data_decode;
    logic [9:0] words [5];
    logic [7:0] exp_d [5];
    words = '{10'b0100000000, 10'b1111111111, 10'b1000000000, 10'b1011111111, 10'b0100000001};
    exp_d = '{8'h00, 8'h00, 8'hFF, 8'hFE, 8'h03};
    for (int i = 0; i < 5; i++) begin
      drive(words[i]);
      drive(T00);
      n_checks++;
      if (o_de !== 1'b0) begin
        n_fail++;
        $display("FAIL data_latency word=%b got de=%b want 0 two cycles after input", words[i], o_de);
      end
      drive(T00);
      n_checks++;
      if (o_de !== 1'b1 || o_data !== exp_d[i] || o_ctrl !== 2'b00) begin
        n_fail++;
        $display("FAIL data_decode word=%b got de=%b data=%h ctrl=%b want de=1 data=%h ctrl=00",
                 words[i], o_de, o_data, o_ctrl, exp_d[i]);
      end
    end
  endtask

  task automatic test_control_values;
    logic [9:0] seq [6];
    logic [1:0] exp_c [6];
    seq   = '{T00, T01, T10, T11, T00, T00};
    exp_c = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      if (i >= 2) begin
        n_checks++;
        if (o_de !== 1'b0 || o_ctrl !== exp_c[i-2] || o_data !== 8'h00) begin
          n_fail++;
          $display("FAIL ctrl_value idx=%0d got de=%b ctrl=%b data=%h want de=0 ctrl=%b data=00",
                   i - 2, o_de, o_ctrl, o_data, exp_c[i-2]);
        end
      end
    end
  endtask

  task automatic test_lock_loss;
    for (int i = 1; i <= 70; i++) begin
      drive(DATA_ZERO);
      if (i == 60) begin
        n_checks++;
        if (o_locked !== 1'b1 || o_de !== 1'b1 || o_data !== 8'h00) begin
          n_fail++;
          $display("FAIL lock_hold got locked=%b de=%b data=%h want 1 1 00", o_locked, o_de, o_data);
        end
      end
    end
    n_checks++;
    if ({o_locked, o_de, o_ctrl, o_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL lock_loss got locked=%b de=%b ctrl=%b data=%h want all 0",
               o_locked, o_de, o_ctrl, o_data);
    end
`ifdef TMDS_RX_DEBUG_EN
    n_checks++;
    if (o_offset !== 4'd1 || o_relock_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL lock_loss_dbg got offset=%0d relock=%0d want 1 1", o_offset, o_relock_cnt);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    i_raw    = '0;
    test_reset();
    test_misaligned_lock();
    test_reset_while_locked();
    test_aligned_lock();
    test_data_decode();
    test_control_values();
    test_lock_loss();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
